// File: rtl/acc_pkg.sv
// Shared helpers for the access-order tracker: bit counting and width derivation.
package acc_pkg;

  // Widest requester vector the helpers accept; narrower vectors are zero-padded.
  localparam int MAX_NCH = 8;

  function automatic int popcount(input logic [MAX_NCH-1:0] vec);
    int n;
    n = 0;
    for (int i = 0; i < MAX_NCH; i++) begin
      if (vec[i]) n++;
    end
    return n;
  endfunction

  // Number of set bits strictly below position idx.
  function automatic int prefix_offset(input logic [MAX_NCH-1:0] vec, input int idx);
    int n;
    n = 0;
    for (int i = 0; i < MAX_NCH; i++) begin
      if (vec[i] && (i < idx)) n++;
    end
    return n;
  endfunction

  function automatic int id_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/acc_push_enc.sv
// Push encoder: turns the request vector into per-channel slot offsets and a push count.
module acc_push_enc
  import acc_pkg::*;
#(
  parameter int NCH = 2,
  localparam int PW = $clog2(NCH + 1)
) (
  input  logic [NCH-1:0]         push_vec,
  output logic [NCH-1:0][PW-1:0] wr_off,
  output logic [PW-1:0]          npush
);

  logic [MAX_NCH-1:0] vec_pad;

  // Lower channel indices take the earlier slots, so each offset is the count of requesters below it.
  always_comb begin
    vec_pad = '0;
    vec_pad[NCH-1:0] = push_vec;
    npush = PW'(popcount(vec_pad));
    wr_off = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_off[i] = PW'(prefix_offset(vec_pad, i));
    end
  end

endmodule

// File: rtl/acc_order_ctrl.sv
// Access-order tracker: records channel IDs of pushed entries in arrival order
// and presents the oldest NCH IDs as registered head outputs.
module acc_order_ctrl
  import acc_pkg::*;
#(
  parameter int NCH = 2,
  parameter int DEPTH = 128,
  localparam int IDW = id_width(NCH),
  localparam int AW = ptr_width(DEPTH),
  localparam int PW = $clog2(NCH + 1)
) (
  input  logic               WCLK,
  input  logic               RESET_N,
  input  logic               CLR,
  input  logic [NCH-1:0]     PUSH,
  input  logic [PW-1:0]      POP_NUM,
  output logic [NCH*IDW-1:0] HEAD_ID,
  output logic [NCH-1:0]     HEAD_VLD,
  output logic [AW:0]        COUNT,
  output logic               FULL,
  output logic               EMPTY,
  output logic               OVF_ERR,
  output logic               UDF_ERR
);

  logic [IDW-1:0]         mem_q [DEPTH];
  logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   full_q, full_d, empty_q, empty_d;
  logic                   ovf_q, ovf_d, udf_q, udf_d;
  logic [NCH*IDW-1:0]     head_id_q, head_id_d;
  logic [NCH-1:0]         head_vld_q, head_vld_d;

  logic [NCH-1:0][PW-1:0] wr_off;
  logic [PW-1:0]          npush;
  logic [AW+1:0]          cnt_ext, pop_ext, pops, after_pop, npush_ext;
  logic                   udf_hit, accept;
  logic [NCH-1:0]         wr_en;
  logic [NCH-1:0][AW-1:0] wr_addr, rd_addr;
  logic [NCH-1:0][IDW-1:0] rd_id;

  acc_push_enc #(.NCH(NCH)) u_push_enc (
    .push_vec (PUSH),
    .wr_off   (wr_off),
    .npush    (npush)
  );

  // Pop clamp, all-or-nothing push acceptance, and next pointer/count/error state.
  always_comb begin
    cnt_ext   = {1'b0, count_q};
    pop_ext   = (AW+2)'(POP_NUM);
    npush_ext = (AW+2)'(npush);
    udf_hit   = (pop_ext > cnt_ext);
    pops      = udf_hit ? cnt_ext : pop_ext;
    after_pop = cnt_ext - pops;
    accept    = ((after_pop + npush_ext) <= (AW+2)'(DEPTH));
    wr_en     = '0;
    wr_addr   = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      wr_addr[ch] = wptr_q + AW'(wr_off[ch]);
    end
    if (CLR) begin
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      count_d = (AW+1)'(after_pop + (accept ? npush_ext : '0));
      rptr_d  = rptr_q + AW'(pops);
      wptr_d  = accept ? (wptr_q + AW'(npush)) : wptr_q;
      ovf_d   = ovf_q | ~accept;
      udf_d   = udf_q | udf_hit;
      wr_en   = accept ? PUSH : '0;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == (AW+1)'(DEPTH));
  end

  // Next head view; entries written this edge are forwarded so they show one cycle after the push.
  always_comb begin
    rd_addr    = '0;
    rd_id      = '0;
    head_vld_d = '0;
    head_id_d  = '0;
    for (int k = 0; k < NCH; k++) begin
      rd_addr[k] = rptr_d + AW'(k);
      rd_id[k]   = mem_q[rd_addr[k]];
      for (int ch = 0; ch < NCH; ch++) begin
        if (wr_en[ch] && (wr_addr[ch] == rd_addr[k])) rd_id[k] = IDW'(ch);
      end
      head_vld_d[k] = ((AW+1)'(k) < count_d);
      if (head_vld_d[k]) head_id_d[k*IDW +: IDW] = rd_id[k];
    end
  end

  // ID storage; contents need no reset because unoccupied slots are never shown.
  always_ff @(posedge WCLK) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (wr_en[ch]) mem_q[wr_addr[ch]] <= IDW'(ch);
    end
  end

  // Control and head registers.
  always_ff @(posedge WCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      head_id_q  <= '0;
      head_vld_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      head_id_q  <= head_id_d;
      head_vld_q <= head_vld_d;
    end
  end

  assign HEAD_ID  = head_id_q;
  assign HEAD_VLD = head_vld_q;
  assign COUNT    = count_q;
  assign FULL     = full_q;
  assign EMPTY    = empty_q;
  assign OVF_ERR  = ovf_q;
  assign UDF_ERR  = udf_q;

endmodule

// File: tb/tb_acc_order_ctrl.sv
// Bench for acc_order_ctrl: a 2-channel/128-deep instance driven against a queue
// scoreboard, plus a 4-channel/8-deep instance for ordering and async reset.
module tb_acc_order_ctrl;

  logic WCLK = 1'b0;
  always #5 WCLK = ~WCLK;

  // 2-channel instance
  logic       rst2_n, clr2;
  logic [1:0] push2, pop2, hid2, hvld2;
  logic [7:0] count2;
  logic       full2, empty2, ovf2, udf2;

  // 4-channel instance
  logic       rst4_n, clr4;
  logic [3:0] push4, hvld4, count4;
  logic [2:0] pop4;
  logic [7:0] hid4;
  logic       full4, empty4, ovf4, udf4;

  acc_order_ctrl #(.NCH(2), .DEPTH(128)) u_dut2 (
    .WCLK(WCLK), .RESET_N(rst2_n), .CLR(clr2), .PUSH(push2), .POP_NUM(pop2),
    .HEAD_ID(hid2), .HEAD_VLD(hvld2), .COUNT(count2), .FULL(full2),
    .EMPTY(empty2), .OVF_ERR(ovf2), .UDF_ERR(udf2)
  );

  acc_order_ctrl #(.NCH(4), .DEPTH(8)) u_dut4 (
    .WCLK(WCLK), .RESET_N(rst4_n), .CLR(clr4), .PUSH(push4), .POP_NUM(pop4),
    .HEAD_ID(hid4), .HEAD_VLD(hvld4), .COUNT(count4), .FULL(full4),
    .EMPTY(empty4), .OVF_ERR(ovf4), .UDF_ERR(udf4)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int q[$];
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_d2(input string tag);
    logic [1:0] ev, eid;
    ev  = '0;
    eid = '0;
    for (int k = 0; k < 2; k++) begin
      if (k < q.size()) begin
        ev[k]  = 1'b1;
        eid[k] = (q[k] == 1);
      end
    end
    chk({tag, " count"}, 32'(count2), 32'(q.size()));
    chk({tag, " head_vld"}, 32'(hvld2), 32'(ev));
    chk({tag, " head_id"}, 32'(hid2), 32'(eid));
    chk({tag, " empty"}, 32'(empty2), 32'(q.size() == 0));
    chk({tag, " full"}, 32'(full2), 32'(q.size() == 128));
    chk({tag, " ovf"}, 32'(ovf2), 32'(m_ovf));
    chk({tag, " udf"}, 32'(udf2), 32'(m_udf));
  endtask

  // Drive one cycle on the 2-channel instance; the scoreboard is updated from
  // the pre-edge occupancy, then the registered outputs are compared after the edge.
  task automatic step(input string tag, input logic [1:0] push, input int popn, input logic clr);
    int np, pops;
    @(negedge WCLK);
    push2 = push;
    pop2  = 2'(popn);
    clr2  = clr;
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      np   = int'(push[0]) + int'(push[1]);
      pops = (popn > q.size()) ? q.size() : popn;
      if (popn > q.size()) m_udf = 1'b1;
      repeat (pops) void'(q.pop_front());
      if (q.size() + np <= 128) begin
        if (push[0]) q.push_back(0);
        if (push[1]) q.push_back(1);
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge WCLK);
    #1;
    check_d2(tag);
    push2 = '0;
    pop2  = '0;
    clr2  = 1'b0;
  endtask

  initial begin
    rst2_n = 1'b0; clr2 = 1'b0; push2 = '0; pop2 = '0;
    rst4_n = 1'b0; clr4 = 1'b0; push4 = '0; pop4 = '0;
    repeat (2) @(posedge WCLK);
    #1;
    check_d2("reset");
    chk("d4 reset empty", 32'(empty4), 32'd1);
    @(negedge WCLK);
    rst2_n = 1'b1;
    rst4_n = 1'b1;

    // Both channels push in one cycle, then drain.
    step("dual push", 2'b11, 0, 1'b0);
    step("drain", 2'b00, 2, 1'b0);

    // Alternating single pushes, then paired pops.
    for (int i = 0; i < 6; i++) step("alt push", (i % 2 == 0) ? 2'b01 : 2'b10, 0, 1'b0);
    for (int i = 0; i < 3; i++) step("pair pop", 2'b00, 2, 1'b0);

    // Fill to 127, rejected push, then accepted push with a pop to reach FULL.
    for (int i = 0; i < 63; i++) step("fill", 2'b11, 0, 1'b0);
    step("fill 127", 2'b01, 0, 1'b0);
    step("reject at 127", 2'b11, 0, 1'b0);
    step("accept with pop", 2'b11, 1, 1'b0);
    step("full push pop", 2'b10, 1, 1'b0);
    step("clr after ovf", 2'b11, 2, 1'b1);

    // Underflow at COUNT=1 pops only the one entry.
    step("one entry", 2'b01, 0, 1'b0);
    step("underflow", 2'b00, 2, 1'b0);
    step("after udf push", 2'b10, 0, 1'b0);
    step("after udf pop", 2'b00, 1, 1'b0);
    step("clr after udf", 2'b00, 0, 1'b1);

    // Bring wptr and rptr to 127, then straddle the wrap.
    for (int i = 0; i < 63; i++) step("wrap fill", 2'b11, 0, 1'b0);
    step("wrap fill 127", 2'b01, 0, 1'b0);
    for (int i = 0; i < 63; i++) step("wrap drain", 2'b00, 2, 1'b0);
    step("wrap drain last", 2'b00, 1, 1'b0);
    step("wrap push", 2'b11, 0, 1'b0);
    step("wrap pop0", 2'b00, 1, 1'b0);
    step("wrap pop1", 2'b00, 1, 1'b0);
    step("empty push pop", 2'b11, 2, 1'b0);
    step("post wrap pop", 2'b00, 2, 1'b0);

    // 4-channel ordering: PUSH=1010 gives IDs 1 then 3.
    @(negedge WCLK);
    push4 = 4'b1010;
    @(posedge WCLK);
    #1;
    chk("d4 count", 32'(count4), 32'd2);
    chk("d4 head_vld", 32'(hvld4), 32'h3);
    chk("d4 head_id", 32'(hid4), 32'h0D);
    @(negedge WCLK);
    push4 = 4'b0101;
    pop4  = 3'd1;
    @(posedge WCLK);
    #1;
    chk("d4 count2", 32'(count4), 32'd3);
    chk("d4 head_vld2", 32'(hvld4), 32'h7);
    chk("d4 head_id2", 32'(hid4), 32'h23);
    chk("d4 empty2", 32'(empty4), 32'd0);
    push4 = '0;
    pop4  = '0;

    // Asynchronous reset between clock edges.
    #2;
    rst4_n = 1'b0;
    #1;
    chk("d4 async count", 32'(count4), 32'd0);
    chk("d4 async head_vld", 32'(hvld4), 32'd0);
    chk("d4 async head_id", 32'(hid4), 32'd0);
    chk("d4 async empty", 32'(empty4), 32'd1);
    chk("d4 async full", 32'(full4), 32'd0);
    chk("d4 async ovf", 32'(ovf4), 32'd0);
    chk("d4 async udf", 32'(udf4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
